// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: AXI response codes and a width helper
// that never returns zero (used for index/pointer widths).
package axi_ic_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    if (n > 2) r = $clog2(n);
    return r;
  endfunction

endpackage

// File: rtl/dsp_wresp_fifo.sv
// Synchronous show-ahead FIFO used for the AW order queue and the per-slave
// B response queues. A push while full is dropped even if a pop coincides.
module dsp_wresp_fifo
  import axi_ic_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              ACLK_i,
  input  logic              ARESET_i,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned AW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_wr   = wr_en & ~full_o;
  assign do_rd   = rd_en & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the counter alone defines validity.
  always_ff @(posedge ACLK_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dsp_wresp_router.sv
// Write-response dispatcher: returns per-slave B responses to one master in AW
// order, with local DECERR. Optional BID check enabled by DSP_WRESP_ID_CHECK_EN.
module dsp_wresp_router
  import axi_ic_pkg::*;
#(
  parameter int unsigned SLV_AMT         = 2,
  parameter int unsigned OUTSTANDING_AMT = 8,
  parameter int unsigned RESP_DEPTH      = 4,
  parameter int unsigned TRANS_MST_ID_W  = 5,
  parameter int unsigned TRANS_WR_RESP_W = 2,
  parameter int unsigned SLV_ID_W        = clog2_min1(SLV_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [SLV_ID_W-1:0]                   dsp_AW_slv_id_i,
  input  logic [TRANS_MST_ID_W-1:0]             dsp_AW_mst_id_i,
  input  logic                                  dsp_AW_shift_en_i,
  output logic                                  dsp_AW_ready_o,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]     sa_BID_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]    sa_BRESP_i,
  input  logic [SLV_AMT-1:0]                    sa_BVALID_i,
  output logic [SLV_AMT-1:0]                    sa_BREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]            m_BRESP_o,
  output logic                                  m_BVALID_o,
  input  logic                                  m_BREADY_i,
  output logic [$clog2(OUTSTANDING_AMT+2)-1:0]  outstanding_cnt_o,
  output logic                                  id_err_o
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING_AMT + 2);
  localparam int unsigned ORD_W = TRANS_MST_ID_W + SLV_ID_W;
  localparam int unsigned RSP_W = TRANS_MST_ID_W + TRANS_WR_RESP_W;

  logic                       ord_full, ord_empty, ord_push;
  logic [ORD_W-1:0]           ord_wdata, ord_rdata;
  logic [SLV_ID_W-1:0]        head_slv;
  logic [TRANS_MST_ID_W-1:0]  head_mst;

  logic [SLV_AMT-1:0]         rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [RSP_W-1:0]           rsp_rdata [SLV_AMT];

  logic                       head_in_map, head_rsp_empty, head_avail;
  logic [RSP_W-1:0]           head_rsp;
  logic [TRANS_MST_ID_W-1:0]  head_bid;
  logic [TRANS_WR_RESP_W-1:0] head_bresp;
  logic                       load, m_hs;

  logic                       bvalid_q, bvalid_d;
  logic [TRANS_MST_ID_W-1:0]  bid_q, bid_d;
  logic [TRANS_WR_RESP_W-1:0] bresp_q, bresp_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // ---------------- AW order queue ----------------
  assign dsp_AW_ready_o = ~ord_full & ~ARESET_i;
  assign ord_push       = dsp_AW_shift_en_i & dsp_AW_ready_o;
  assign ord_wdata      = {dsp_AW_mst_id_i, dsp_AW_slv_id_i};
  assign head_mst       = ord_rdata[ORD_W-1 -: TRANS_MST_ID_W];
  assign head_slv       = ord_rdata[SLV_ID_W-1:0];

  dsp_wresp_fifo #(
    .DATA_W (ORD_W),
    .DEPTH  (OUTSTANDING_AMT)
  ) u_ord_fifo (
    .ACLK_i   (ACLK_i),
    .ARESET_i (ARESET_i),
    .wr_en    (ord_push),
    .rd_en    (load),
    .data_i   (ord_wdata),
    .data_o   (ord_rdata),
    .empty_o  (ord_empty),
    .full_o   (ord_full)
  );

  // ---------------- per-slave response queues ----------------
  for (genvar s = 0; s < SLV_AMT; s++) begin : g_rsp
    assign sa_BREADY_o[s] = ~rsp_full[s] & ~ARESET_i;
    assign rsp_push[s]    = sa_BVALID_i[s] & sa_BREADY_o[s];
    assign rsp_pop[s]     = load & head_in_map & (head_slv == SLV_ID_W'(s));

    dsp_wresp_fifo #(
      .DATA_W (RSP_W),
      .DEPTH  (RESP_DEPTH)
    ) u_rsp_fifo (
      .ACLK_i   (ACLK_i),
      .ARESET_i (ARESET_i),
      .wr_en    (rsp_push[s]),
      .rd_en    (rsp_pop[s]),
      .data_i   ({sa_BID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W],
                  sa_BRESP_i[s*TRANS_WR_RESP_W +: TRANS_WR_RESP_W]}),
      .data_o   (rsp_rdata[s]),
      .empty_o  (rsp_empty[s]),
      .full_o   (rsp_full[s])
    );
  end

  // Equality scan instead of a range compare: slave ids beyond SLV_AMT fall
  // through as out-of-map, and no index ever exceeds the FIFO array.
  always_comb begin
    head_in_map    = 1'b0;
    head_rsp_empty = 1'b1;
    head_rsp       = '0;
    for (int unsigned s = 0; s < SLV_AMT; s++) begin
      if (head_slv == SLV_ID_W'(s)) begin
        head_in_map    = 1'b1;
        head_rsp_empty = rsp_empty[s];
        head_rsp       = rsp_rdata[s];
      end
    end
  end

  assign head_bid   = head_rsp[RSP_W-1 -: TRANS_MST_ID_W];
  assign head_bresp = head_rsp[TRANS_WR_RESP_W-1:0];
  assign head_avail = ~ord_empty & (~head_in_map | ~head_rsp_empty);
  assign load       = head_avail & (~bvalid_q | m_BREADY_i);
  assign m_hs       = bvalid_q & m_BREADY_i;

  // ---------------- output register ----------------
`ifdef DSP_WRESP_ID_CHECK_EN
  logic id_err_q, id_err_d;
`endif

  always_comb begin
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
`ifdef DSP_WRESP_ID_CHECK_EN
    id_err_d = id_err_q;
`endif
    if (load) begin
      bvalid_d = 1'b1;
      if (!head_in_map) begin
        bid_d   = head_mst;
        bresp_d = TRANS_WR_RESP_W'(RESP_DECERR);
      end else begin
`ifdef DSP_WRESP_ID_CHECK_EN
        if (head_bid != head_mst) begin
          bid_d    = head_mst;
          bresp_d  = TRANS_WR_RESP_W'(RESP_SLVERR);
          id_err_d = 1'b1;
        end else begin
          bid_d   = head_bid;
          bresp_d = head_bresp;
        end
`else
        bid_d   = head_bid;
        bresp_d = head_bresp;
`endif
      end
    end else if (m_BREADY_i) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({ord_push, m_hs})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      cnt_q    <= '0;
    end else begin
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef DSP_WRESP_ID_CHECK_EN
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) id_err_q <= 1'b0;
    else          id_err_q <= id_err_d;
  end
  assign id_err_o = id_err_q;
`else
  assign id_err_o = 1'b0;
`endif

  assign m_BVALID_o        = bvalid_q;
  assign m_BID_o           = bid_q;
  assign m_BRESP_o         = bresp_q;
  assign outstanding_cnt_o = cnt_q;

endmodule

// File: tb/tb_dsp_wresp_router.sv
// Bench for dsp_wresp_router (SLV_AMT=3 so slave id 3 is out of map): queue
// model checked every cycle, plus literal expectations on the delivered B log.
module tb_dsp_wresp_router;

  localparam int unsigned NS = 3;
  localparam int unsigned OA = 8;
  localparam int unsigned RD = 4;
  localparam int unsigned IW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        aw_slv = '0;
  logic [IW-1:0]     aw_mst = '0;
  logic              aw_en = 1'b0;
  logic              aw_ready;
  logic [IW*NS-1:0]  sa_bid = '0;
  logic [2*NS-1:0]   sa_bresp = '0;
  logic [NS-1:0]     sa_bvalid = '0;
  logic [NS-1:0]     sa_bready;
  logic [IW-1:0]     m_bid;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready = 1'b1;
  logic [3:0]        cnt;
  logic              id_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dsp_wresp_router #(
    .SLV_AMT         (NS),
    .OUTSTANDING_AMT (OA),
    .RESP_DEPTH      (RD),
    .TRANS_MST_ID_W  (IW),
    .TRANS_WR_RESP_W (2)
  ) dut (
    .ACLK_i            (clk),
    .ARESET_i          (rst),
    .dsp_AW_slv_id_i   (aw_slv),
    .dsp_AW_mst_id_i   (aw_mst),
    .dsp_AW_shift_en_i (aw_en),
    .dsp_AW_ready_o    (aw_ready),
    .sa_BID_i          (sa_bid),
    .sa_BRESP_i        (sa_bresp),
    .sa_BVALID_i       (sa_bvalid),
    .sa_BREADY_o       (sa_bready),
    .m_BID_o           (m_bid),
    .m_BRESP_o         (m_bresp),
    .m_BVALID_o        (m_bvalid),
    .m_BREADY_i        (m_bready),
    .outstanding_cnt_o (cnt),
    .id_err_o          (id_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int slv; int mst; } ord_t;
  typedef struct { int slv; int bid; int resp; } rsp_t;
  ord_t ord_q[$];
  rsp_t rsp_q[$];
  int   e_valid = 0, e_bid = 0, e_bresp = 0, e_cnt = 0, e_err = 0;
  bit   model_ok = 0;

  function automatic int cnt_of(input int s);
    int n = 0;
    foreach (rsp_q[i]) if (rsp_q[i].slv == s) n++;
    return n;
  endfunction

  function automatic int first_of(input int s);
    foreach (rsp_q[i]) if (rsp_q[i].slv == s) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit   aw_acc, hs, can_load;
    bit   b_acc [NS];
    int   idx;
    ord_t h;
    rsp_t r;
    if (rst) begin
      ord_q.delete();
      rsp_q.delete();
      e_valid = 0; e_bid = 0; e_bresp = 0; e_cnt = 0; e_err = 0;
      model_ok = 1;
    end else if (model_ok) begin
      aw_acc = aw_en && (ord_q.size() < OA);
      for (int s = 0; s < NS; s++) b_acc[s] = sa_bvalid[s] && (cnt_of(s) < RD);
      hs       = (e_valid != 0) && m_bready;
      can_load = (e_valid == 0) || m_bready;
      if (ord_q.size() > 0 && can_load) begin
        h = ord_q[0];
        if (h.slv >= NS) begin
          e_bid = h.mst; e_bresp = 3; e_valid = 1;
          void'(ord_q.pop_front());
        end else begin
          idx = first_of(h.slv);
          if (idx >= 0) begin
            r = rsp_q[idx];
            rsp_q.delete(idx);
            void'(ord_q.pop_front());
            e_valid = 1;
            e_bid = r.bid; e_bresp = r.resp;
`ifdef DSP_WRESP_ID_CHECK_EN
            if (r.bid != h.mst) begin
              e_bid = h.mst; e_bresp = 2; e_err = 1;
            end
`endif
          end else if (hs) e_valid = 0;
        end
      end else if (hs) e_valid = 0;
      if (aw_acc) ord_q.push_back('{slv: int'(aw_slv), mst: int'(aw_mst)});
      for (int s = 0; s < NS; s++)
        if (b_acc[s]) rsp_q.push_back('{slv: s, bid: int'(sa_bid[s*IW +: IW]),
                                        resp: int'(sa_bresp[s*2 +: 2])});
      e_cnt = e_cnt + int'(aw_acc) - int'(hs);
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      chk("m_BVALID", int'(m_bvalid), e_valid);
      chk("m_BID", int'(m_bid), e_bid);
      chk("m_BRESP", int'(m_bresp), e_bresp);
      chk("outstanding", int'(cnt), e_cnt);
      chk("id_err", int'(id_err), e_err);
      chk("aw_ready", int'(aw_ready), int'(!rst && ord_q.size() < OA));
      for (int s = 0; s < NS; s++)
        chk($sformatf("sa_BREADY[%0d]", s), int'(sa_bready[s]), int'(!rst && cnt_of(s) < RD));
    end
  end

  // Log of master handshakes seen at the DUT port, with cycle stamps.
  int log_bid[$], log_resp[$], log_cyc[$];
  int cyc_n = 0;
  always @(posedge clk) begin
    if (!rst && m_bvalid === 1'b1 && m_bready) begin
      log_bid.push_back(int'(m_bid));
      log_resp.push_back(int'(m_bresp));
      log_cyc.push_back(cyc_n);
    end
    cyc_n++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic aw(input logic [1:0] s, input logic [IW-1:0] id);
    aw_slv = s; aw_mst = id; aw_en = 1'b1;
    tick(1);
    aw_en = 1'b0;
  endtask

  task automatic send_b(input int s, input logic [IW-1:0] bid, input logic [1:0] resp, input int n);
    int got = 0;
    int guard = 0;
    sa_bid[s*IW +: IW] = bid;
    sa_bresp[s*2 +: 2] = resp;
    sa_bvalid[s] = 1'b1;
    while (got < n && guard < 200) begin
      @(posedge clk);
      if (sa_bready[s]) got++;
      guard++;
      @(negedge clk);
    end
    sa_bvalid[s] = 1'b0;
    if (got < n) chk("send_b_timeout", got, n);
  endtask

  task automatic clear_log();
    log_bid.delete(); log_resp.delete(); log_cyc.delete();
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    // idle after reset
    chk("t1_bvalid", int'(m_bvalid), 0);
    chk("t1_bready", int'(sa_bready), 3'b111);
    chk("t1_awready", int'(aw_ready), 1);
    chk("t1_cnt", int'(cnt), 0);

    // in-order return despite slave 1 answering first
    clear_log();
    aw(2'd0, 5'd3);
    aw(2'd1, 5'd7);
    send_b(1, 5'd7, 2'b00, 1);
    tick(1);
    send_b(0, 5'd3, 2'b00, 1);
    tick(4);
    chk("t2_count", log_bid.size(), 2);
    if (log_bid.size() == 2) begin
      chk("t2_first_bid", log_bid[0], 3);
      chk("t2_second_bid", log_bid[1], 7);
      chk("t2_resp", log_resp[0] + log_resp[1], 0);
      chk("t2_back_to_back", log_cyc[1] - log_cyc[0], 1);
    end
    chk("t2_cnt", int'(cnt), 0);

    // order queue full, then response queue full
    m_bready = 1'b0;
    aw_slv = 2'd0; aw_mst = 5'd5; aw_en = 1'b1;
    tick(8);
    chk("t3_awready_full", int'(aw_ready), 0);
    chk("t3_cnt8", int'(cnt), 8);
    aw_mst = 5'd31;
    tick(1);
    aw_en = 1'b0;
    chk("t3_ninth_ignored", int'(cnt), 8);
    send_b(0, 5'd5, 2'b00, 5);
    chk("t3_bready0_low", int'(sa_bready[0]), 0);
    chk("t3_bvalid", int'(m_bvalid), 1);
    chk("t3_awready_again", int'(aw_ready), 1);

    // hold under back-pressure, then drain
    tick(5);
    chk("t4_bid_held", int'(m_bid), 5);
    chk("t4_bvalid_held", int'(m_bvalid), 1);
    clear_log();
    m_bready = 1'b1;
    send_b(0, 5'd5, 2'b00, 3);
    tick(6);
    chk("t4_drained", log_bid.size(), 8);
    if (log_bid.size() == 8) chk("t4_contiguous", log_cyc[7] - log_cyc[0], 7);
    chk("t4_cnt0", int'(cnt), 0);

    // out-of-map slave -> local DECERR
    aw(2'd3, 5'd9);
    tick(3);
    chk("t5_bid", log_bid[$], 9);
    chk("t5_decerr", log_resp[$], 3);

    // BID mismatch, then a matching EXOKAY pass-through
    aw(2'd2, 5'd4);
    send_b(2, 5'd5, 2'b00, 1);
    tick(3);
`ifdef DSP_WRESP_ID_CHECK_EN
    chk("t6_bid", log_bid[$], 4);
    chk("t6_slverr", log_resp[$], 2);
    chk("t6_id_err", int'(id_err), 1);
`else
    chk("t6_bid", log_bid[$], 5);
    chk("t6_resp", log_resp[$], 0);
    chk("t6_id_err", int'(id_err), 0);
`endif
    aw(2'd2, 5'd6);
    send_b(2, 5'd6, 2'b01, 1);
    tick(3);
    chk("t6_pass_bid", log_bid[$], 6);
    chk("t6_pass_resp", log_resp[$], 1);
`ifdef DSP_WRESP_ID_CHECK_EN
    chk("t6_id_err_sticky", int'(id_err), 1);
`endif

    // reset mid-transfer discards everything
    m_bready = 1'b0;
    aw(2'd1, 5'd6);
    aw(2'd0, 5'd2);
    send_b(1, 5'd6, 2'b00, 1);
    tick(2);
    chk("t7_bvalid_pre", int'(m_bvalid), 1);
    chk("t7_cnt_pre", int'(cnt), 2);
    rst = 1'b1;
    tick(2);
    chk("t7_awready_rst", int'(aw_ready), 0);
    chk("t7_bready_rst", int'(sa_bready), 0);
    rst = 1'b0;
    m_bready = 1'b1;
    tick(4);
    chk("t7_bvalid_post", int'(m_bvalid), 0);
    chk("t7_cnt_post", int'(cnt), 0);
    chk("t7_id_err_post", int'(id_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
